// File: rtl/stack_ctrl_if.sv
// stack_ctrl operation port: valid/ready request bundle.
// Master issues PUSH/POP/REPLACE/CLEAR; slave accepts in IDLE.
interface stack_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              op_valid;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] op_data;
  logic              op_ready;

  modport master (
    output op_valid,
    output op_code,
    output op_data,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_data,
    output op_ready
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: TOS/NOS registers plus RAM spill area.
// Hides RAM write pulse and read latency behind op port.
module stack_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              resetn,
  stack_ctrl_if.slave       op,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] next,
  output logic [ADDR_W:0]   depth,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD1  = 2'd2;
  localparam logic [1:0] S_RD2  = 2'd3;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_REPL = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  localparam int CAP_I = (1 << ADDR_W) + 2;
  localparam logic [ADDR_W:0] CAP = CAP_I[ADDR_W:0];
  localparam logic [ADDR_W:0] D0  = '0;
  localparam logic [ADDR_W:0] D1  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] D2  = {{(ADDR_W-1){1'b0}}, 2'b10};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic [ADDR_W:0]   depth_q, depth_d;
  logic [ADDR_W:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d;

  logic              idle;
  logic              accept;
  logic [ADDR_W:0]   sp_m1;
  logic [ADDR_W:0]   sp_p1;
  logic [ADDR_W:0]   dep_m1;
  logic [ADDR_W:0]   dep_p1;

  assign idle   = (state_q == S_IDLE);
  assign accept = op.op_valid & idle;
  assign sp_m1  = sp_q - D1;
  assign sp_p1  = sp_q + D1;
  assign dep_m1 = depth_q - D1;
  assign dep_p1 = depth_q + D1;

  assign op.op_ready = idle;
  assign top         = top_q;
  assign next        = next_q;
  assign depth       = depth_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_wen     = wen_q;

  // Next-state: decode accepted op, sequence RAM spill/refill
  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    next_d  = next_q;
    depth_d = depth_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op.op_code)
            OP_PUSH: begin
              if (depth_q == CAP) begin
                ovf_d = 1'b1;
              end else if (depth_q < D2) begin
                top_d   = op.op_data;
                next_d  = top_q;
                depth_d = dep_p1;
              end else begin
                addr_d  = sp_q[ADDR_W-1:0];
                wdata_d = next_q;
                wen_d   = 1'b1;
                sp_d    = sp_p1;
                next_d  = top_q;
                top_d   = op.op_data;
                depth_d = dep_p1;
                state_d = S_WR;
              end
            end
            OP_POP: begin
              if (depth_q == D0) begin
                unf_d = 1'b1;
              end else if (depth_q <= D2) begin
                top_d   = next_q;
                next_d  = '0;
                depth_d = dep_m1;
              end else begin
                top_d   = next_q;
                depth_d = dep_m1;
                addr_d  = sp_m1[ADDR_W-1:0];
                sp_d    = sp_m1;
                state_d = S_RD1;
              end
            end
            OP_REPL: begin
              if (depth_q < D2) begin
                unf_d = 1'b1;
              end else if (depth_q == D2) begin
                top_d   = op.op_data;
                next_d  = '0;
                depth_d = D1;
              end else begin
                top_d   = op.op_data;
                depth_d = dep_m1;
                addr_d  = sp_m1[ADDR_W-1:0];
                sp_d    = sp_m1;
                state_d = S_RD1;
              end
            end
            OP_CLR: begin
              top_d   = '0;
              next_d  = '0;
              depth_d = '0;
              sp_d    = '0;
              ovf_d   = 1'b0;
              unf_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_WR: begin
        state_d = S_IDLE;
      end
      S_RD1: begin
        state_d = S_RD2;
      end
      S_RD2: begin
        next_d  = ram_rdata;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops ram_wen without a clock
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      top_q   <= '0;
      next_q  <= '0;
      depth_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      next_q  <= next_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: random ops vs. queue-based stack model.
// Driver pushes expectations; negedge monitor checks them.
module tb_stack_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int CAP = (1 << AW) + 2;

  typedef struct {
    logic [DW-1:0] top;
    logic [DW-1:0] nxt;
    logic [AW:0]   depth;
    logic          ovf;
    logic          unf;
    int            busy;
    logic [AW-1:0] raddr;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          CLK;
  logic          resetn;
  logic [DW-1:0] top;
  logic [DW-1:0] next;
  logic [AW:0]   depth;
  logic          overflow;
  logic          underflow;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;
  logic [DW-1:0] ram_rdata;

  stack_ctrl_if #(.DATA_W(DW)) opif ();

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK       (CLK),
    .resetn    (resetn),
    .op        (opif.slave),
    .top       (top),
    .next      (next),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .ram_rdata (ram_rdata)
  );

  logic [DW-1:0] mem [1<<AW];

  always @(posedge CLK) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] stk [$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  exp_t          expq [$];
  wr_t           wq [$];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask

  task automatic model(input logic [1:0] c, input logic [DW-1:0] d);
    exp_t e;
    int s;
    s = stk.size();
    e.busy  = 0;
    e.raddr = '0;
    case (c)
      2'd0: begin
        if (s == CAP) m_ovf = 1'b1;
        else begin
          if (s >= 2) begin
            wq.push_back('{a: AW'(s - 2), d: stk[1]});
            e.busy = 1;
          end
          stk.push_front(d);
        end
      end
      2'd1: begin
        if (s == 0) m_unf = 1'b1;
        else begin
          void'(stk.pop_front());
          if (s > 2) begin
            e.busy  = 2;
            e.raddr = AW'(s - 3);
          end
        end
      end
      2'd2: begin
        if (s < 2) m_unf = 1'b1;
        else begin
          void'(stk.pop_front());
          void'(stk.pop_front());
          stk.push_front(d);
          if (s > 2) begin
            e.busy  = 2;
            e.raddr = AW'(s - 3);
          end
        end
      end
      default: begin
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    endcase
    e.depth = (AW+1)'(stk.size());
    e.top   = (stk.size() > 0) ? stk[0] : '0;
    e.nxt   = (stk.size() > 1) ? stk[1] : '0;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    expq.push_back(e);
  endtask

  // called just after a posedge; returns after the accept edge + 1
  task automatic do_op(input logic [1:0] c, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    opif.op_valid = 1'b1;
    opif.op_code  = c;
    opif.op_data  = d;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      if (opif.op_ready) begin
        ok = 1'b1;
        model(c, d);
      end
      @(posedge CLK);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no op_ready want op_ready");
    end
    opif.op_valid = 1'b0;
  endtask

  bit   mon_en = 1'b0;
  bit   pend   = 1'b0;
  bit   first  = 1'b0;
  int   bcnt   = 0;
  logic prev_wen = 1'b0;
  exp_t me;
  wr_t  mw;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (pend) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exp_empty: got accept want none");
          pend = 1'b0;
        end else begin
          me = expq[0];
          if (first) begin
            chk("top", top, me.top);
            chk("depth", depth, me.depth);
            if (me.busy == 2) chk("rd_addr", ram_addr, me.raddr);
            first = 1'b0;
          end
          if (opif.op_ready) begin
            void'(expq.pop_front());
            chk("next", next, me.nxt);
            chk("overflow", overflow, me.ovf);
            chk("underflow", underflow, me.unf);
            chk("busy_cycles", bcnt, me.busy);
            pend = 1'b0;
          end else begin
            bcnt++;
            if (bcnt > 5) begin
              total++;
              bad++;
              $display("FAIL busy_timeout: got %0d want <=2", bcnt);
              void'(expq.pop_front());
              pend = 1'b0;
            end
          end
        end
      end
      if (ram_wen) begin
        if (prev_wen) chk("wen_pulse", 1, 0);
        if (wq.size() == 0) begin
          chk("wen_unexp", ram_wen, 0);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", ram_addr, mw.a);
          chk("wr_data", ram_wdata, mw.d);
        end
      end
      prev_wen = ram_wen;
      if (opif.op_valid && opif.op_ready) begin
        pend  = 1'b1;
        first = 1'b1;
        bcnt  = 0;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 6; i++) @(posedge CLK);
    #1;
  endtask

  int r;
  logic [1:0] c;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    opif.op_valid = 1'b0;
    opif.op_code  = 2'd0;
    opif.op_data  = '0;
    resetn = 1'b0;
    #12;
    chk("rst_ready", opif.op_ready, 1);
    chk("rst_top", top, 0);
    chk("rst_next", next, 0);
    chk("rst_depth", depth, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    chk("rst_ram", {ram_addr, ram_wdata, ram_wen}, 0);
    @(negedge CLK);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    do_op(2'd0, 32'h11);
    do_op(2'd0, 32'h22);
    do_op(2'd0, 32'h33);
    do_op(2'd1, 32'h0);
    do_op(2'd3, 32'h0);
    do_op(2'd0, 32'h1);
    do_op(2'd0, 32'h2);
    do_op(2'd0, 32'h3);
    do_op(2'd2, 32'h5);
    do_op(2'd3, 32'h0);
    for (int i = 0; i < CAP; i++) do_op(2'd0, $urandom);
    do_op(2'd0, 32'hdead);
    do_op(2'd1, 32'h0);
    do_op(2'd2, 32'h77);
    do_op(2'd3, 32'h0);
    do_op(2'd1, 32'h0);
    do_op(2'd2, 32'h0);
    do_op(2'd3, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(99);
      if (r < 50)      c = 2'd0;
      else if (r < 78) c = 2'd1;
      else if (r < 98) c = 2'd2;
      else             c = 2'd3;
      do_op(c, $urandom);
      if ($urandom_range(3) == 0) begin
        @(posedge CLK);
        #1;
      end
    end

    do_op(2'd3, 32'h0);
    do_op(2'd0, 32'ha);
    do_op(2'd0, 32'hb);
    do_op(2'd0, 32'hc);
    drain();
    chk("expq_left", expq.size(), 0);
    chk("wq_left", wq.size(), 0);
    mon_en = 1'b0;

    opif.op_valid = 1'b1;
    opif.op_code  = 2'd0;
    opif.op_data  = 32'hd;
    @(posedge CLK);
    #1;
    opif.op_valid = 1'b0;
    chk("mid_wen", ram_wen, 1);
    resetn = 1'b0;
    #1;
    chk("async_wen", ram_wen, 0);
    chk("async_depth", depth, 0);
    chk("async_ready", opif.op_ready, 1);
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("post_depth", depth, 0);
    chk("post_ready", opif.op_ready, 1);
    chk("post_top", top, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
